// File: rtl/sequence_gen.sv
// Fibonacci / triangle sequence generator driven by a held load handshake.
// Errors (illegal mode) and 64-bit overflow are sticky until clear or reset.
module sequence_gen (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        fibonacci,
    input  logic        triangle,
    input  logic        clear,
    input  logic [15:0] order,
    input  logic [63:0] data_in,
    output logic        done,
    output logic        error,
    output logic        overflow,
    output logic [63:0] data_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_DONE,
        S_ERR,
        S_OVF
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] acc_q, acc_d;
    logic [63:0] prev_q, prev_d;
    logic [63:0] data_out_q, data_out_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] order_q, order_d;
    logic        fib_q, fib_d;
    logic [63:0] addend;
    logic [64:0] sum;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            prev_q     <= '0;
            cnt_q      <= '0;
            order_q    <= '0;
            fib_q      <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            prev_q     <= prev_d;
            cnt_q      <= cnt_d;
            order_q    <= order_d;
            fib_q      <= fib_d;
            data_out_q <= data_out_d;
        end
    end

    // NOTE: every signal gets a default at the top of the block so no path
    // through the case statement can leave one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        prev_d     = prev_q;
        cnt_d      = cnt_q;
        order_d    = order_q;
        fib_d      = fib_q;
        data_out_d = data_out_q;

        // The first Fibonacci step only copies a(0) into a(1), so it never adds.
        addend = fib_q ? prev_q : (64'(cnt_q) + 64'd1);
        if (fib_q && (cnt_q == 16'd0)) begin
            sum = {1'b0, acc_q};
        end else begin
            sum = {1'b0, acc_q} + {1'b0, addend};
        end

        if (clear) begin
            state_d    = S_IDLE;
            data_out_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (load) state_d = S_ARM;
                end
                S_ARM: begin
                    if (!load) begin
                        state_d = S_IDLE;
                    end else begin
                        order_d = order;
                        fib_d   = fibonacci;
                        acc_d   = data_in;
                        prev_d  = data_in;
                        cnt_d   = '0;
                        if (fibonacci == triangle) begin
                            state_d    = S_ERR;
                            data_out_d = '0;
                        end else begin
                            state_d = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (!load) begin
                        state_d = S_IDLE;
                    end else if (cnt_q == order_q) begin
                        state_d    = S_DONE;
                        data_out_d = acc_q;
                    end else if (sum[64]) begin
                        state_d    = S_OVF;
                        data_out_d = acc_q;
                    end else begin
                        acc_d  = sum[63:0];
                        prev_d = acc_q;
                        cnt_d  = cnt_q + 16'd1;
                    end
                end
                S_DONE: begin
                    if (!load) state_d = S_IDLE;
                end
                S_ERR, S_OVF: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Flags decode the state register only, so no input reaches an output.
    always_comb begin
        done     = (state_q == S_DONE);
        error    = (state_q == S_ERR);
        overflow = (state_q == S_OVF);
        data_out = data_out_q;
    end

endmodule

// File: tb/tb_sequence_gen.sv
// Self-checking bench for sequence_gen: directed scenarios plus randomized runs
// compared against a closed-form / array-based reference model.
module tb_sequence_gen;

    logic        clk;
    logic        reset;
    logic        load;
    logic        fibonacci;
    logic        triangle;
    logic        clear;
    logic [15:0] order;
    logic [63:0] data_in;
    logic        done;
    logic        error;
    logic        overflow;
    logic [63:0] data_out;

    int checks;
    int failures;

    localparam logic [63:0] FIB92 = 64'd12200160415121876738;

    sequence_gen dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .fibonacci(fibonacci),
        .triangle (triangle),
        .clear    (clear),
        .order    (order),
        .data_in  (data_in),
        .done     (done),
        .error    (error),
        .overflow (overflow),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    // Reference: result and overflow straight from the sequence definitions.
    function automatic void model(input bit f, input logic [63:0] d, input int n,
                                  output logic [63:0] res, output bit ovf);
        logic [127:0] a_prev, a_cur, nxt, t_prev, t;
        longint kk;
        ovf = 1'b0;
        if (f) begin
            a_prev = {64'd0, d};
            a_cur  = {64'd0, d};
            for (int k = 2; k <= n; k++) begin
                nxt = a_cur + a_prev;
                if (nxt[127:64] != 64'd0) begin
                    ovf = 1'b1;
                    res = a_cur[63:0];
                    return;
                end
                a_prev = a_cur;
                a_cur  = nxt;
            end
            res = a_cur[63:0];
        end else begin
            t_prev = {64'd0, d};
            for (int k = 1; k <= n; k++) begin
                kk = k;
                t  = {64'd0, d} + 128'(kk * (kk + 1) / 2);
                if (t[127:64] != 64'd0) begin
                    ovf = 1'b1;
                    res = t_prev[63:0];
                    return;
                end
                t_prev = t;
            end
            res = t_prev[63:0];
        end
    endfunction

    task automatic start(input bit f, input bit t, input logic [63:0] d, input logic [15:0] n);
        fibonacci = f;
        triangle  = t;
        data_in   = d;
        order     = n;
        load      = 1'b1;
    endtask

    // Counts edges from the one where IDLE first sees load; lat is edges after that one.
    task automatic wait_end(input int limit, input bit scramble, output int lat, output bit timed_out);
        int n_edges;
        n_edges   = 0;
        lat       = 0;
        timed_out = 1'b1;
        while (n_edges < limit) begin
            @(posedge clk); #1;
            n_edges++;
            if (done || error || overflow) begin
                timed_out = 1'b0;
                lat       = n_edges - 1;
                break;
            end
            if (scramble && n_edges >= 2) begin
                order     = 16'($urandom);
                data_in   = {$urandom, $urandom};
                fibonacci = 1'($urandom);
                triangle  = 1'($urandom);
            end
        end
    endtask

    task automatic to_idle();
        load  = 1'b0;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        int lat;
        bit to;
        start(1'b1, 1'b0, 64'd5, 16'd3);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({done, error, overflow} !== 3'b000 || data_out !== 64'd0) begin
                failures++;
                $display("FAIL reset_outputs: got done=%b err=%b ovf=%b data=%0d want 0 0 0 0",
                         done, error, overflow, data_out);
            end
        end
        reset = 1'b0;
        wait_end(50, 1'b0, lat, to);
        checks++;
        if (to || done !== 1'b1 || lat != 5 || data_out !== 64'd15) begin
            failures++;
            $display("FAIL reset_release_run: got to=%b done=%b lat=%0d data=%0d want 0 1 5 15",
                     to, done, lat, data_out);
        end
        to_idle();
    endtask

    task automatic test_fib_handshake();
        int lat;
        bit to;
        start(1'b1, 1'b0, 64'd3, 16'd5);
        wait_end(50, 1'b0, lat, to);
        checks++;
        if (to || done !== 1'b1 || data_out !== 64'd24 || overflow !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL fib_d3_n5: got to=%b done=%b data=%0d ovf=%b err=%b want 0 1 24 0 0",
                     to, done, data_out, overflow, error);
        end
        checks++;
        if (lat != 7) begin
            failures++;
            $display("FAIL fib_latency: got %0d want 7", lat);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b1 || data_out !== 64'd24) begin
                failures++;
                $display("FAIL done_hold cycle %0d: got done=%b data=%0d want 1 24", i, done, data_out);
            end
        end
        load = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL done_fall: got done=%b want 0", done);
        end
        // clear and load together on one edge must land in IDLE, then restart cleanly
        start(1'b1, 1'b0, 64'd3, 16'd5);
        repeat (3) @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({done, error, overflow} !== 3'b000 || data_out !== 64'd0) begin
            failures++;
            $display("FAIL clear_with_load: got done=%b err=%b ovf=%b data=%0d want 0 0 0 0",
                     done, error, overflow, data_out);
        end
        clear = 1'b0;
        wait_end(50, 1'b0, lat, to);
        checks++;
        if (to || done !== 1'b1 || lat != 7 || data_out !== 64'd24) begin
            failures++;
            $display("FAIL after_clear_run: got to=%b done=%b lat=%0d data=%0d want 0 1 7 24",
                     to, done, lat, data_out);
        end
        load = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        // IDLE now holds data_out=24 from the previous completed run
        start(1'b0, 1'b1, 64'd9, 16'd20);
        repeat (5) @(posedge clk);
        #1;
        load = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({done, error, overflow} !== 3'b000 || data_out !== 64'd24) begin
            failures++;
            $display("FAIL abort_in_run: got done=%b err=%b ovf=%b data=%0d want 0 0 0 24",
                     done, error, overflow, data_out);
        end
        repeat (25) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL abort_stays_idle: got done=%b want 0", done);
        end
    endtask

    task automatic test_triangle();
        int lat;
        bit to;
        start(1'b0, 1'b1, 64'd5, 16'd10);
        wait_end(50, 1'b0, lat, to);
        checks++;
        if (to || done !== 1'b1 || data_out !== 64'd60 || lat != 12) begin
            failures++;
            $display("FAIL tri_d5_n10: got to=%b done=%b data=%0d lat=%0d want 0 1 60 12",
                     to, done, data_out, lat);
        end
        to_idle();
        start(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 16'd1);
        wait_end(50, 1'b0, lat, to);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (to || overflow !== 1'b1 || done !== 1'b0 || data_out !== 64'hFFFF_FFFF_FFFF_FFFF) begin
                failures++;
                $display("FAIL tri_overflow_hold %0d: got to=%b ovf=%b done=%b data=%h want 0 1 0 ffffffffffffffff",
                         i, to, overflow, done, data_out);
            end
            load = ~load;
            @(posedge clk); #1;
        end
        to_idle();
        checks++;
        if ({done, error, overflow} !== 3'b000 || data_out !== 64'd0) begin
            failures++;
            $display("FAIL tri_overflow_clear: got done=%b err=%b ovf=%b data=%0d want 0 0 0 0",
                     done, error, overflow, data_out);
        end
    endtask

    task automatic test_fib_boundary();
        int lat;
        bit to;
        start(1'b1, 1'b0, 64'd1, 16'd92);
        wait_end(200, 1'b0, lat, to);
        checks++;
        if (to || done !== 1'b1 || overflow !== 1'b0 || data_out !== FIB92) begin
            failures++;
            $display("FAIL fib_n92: got to=%b done=%b ovf=%b data=%0d want 0 1 0 %0d",
                     to, done, overflow, data_out, FIB92);
        end
        to_idle();
        start(1'b1, 1'b0, 64'd1, 16'd93);
        wait_end(200, 1'b0, lat, to);
        checks++;
        if (to || overflow !== 1'b1 || done !== 1'b0 || data_out !== FIB92) begin
            failures++;
            $display("FAIL fib_n93: got to=%b ovf=%b done=%b data=%0d want 0 1 0 %0d",
                     to, overflow, done, data_out, FIB92);
        end
        to_idle();
    endtask

    task automatic test_mode_error();
        int lat;
        bit to;
        for (int m = 0; m < 2; m++) begin
            start(m == 0, m == 0, 64'd7, 16'd4);
            wait_end(20, 1'b0, lat, to);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (to || error !== 1'b1 || done !== 1'b0 || overflow !== 1'b0 || data_out !== 64'd0) begin
                    failures++;
                    $display("FAIL mode_error m=%0d cyc=%0d: got to=%b err=%b done=%b ovf=%b data=%0d want 0 1 0 0 0",
                             m, i, to, error, done, overflow, data_out);
                end
                load = ~load;
                @(posedge clk); #1;
            end
            to_idle();
            checks++;
            if (error !== 1'b0) begin
                failures++;
                $display("FAIL mode_error_clear m=%0d: got err=%b want 0", m, error);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        bit to;
        logic [63:0] res;
        bit ovf;
        model(1'b1, 64'd2, 50, res, ovf);
        start(1'b1, 1'b0, 64'd2, 16'd50);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({done, error, overflow} !== 3'b000 || data_out !== 64'd0) begin
            failures++;
            $display("FAIL reset_mid_run: got done=%b err=%b ovf=%b data=%0d want 0 0 0 0",
                     done, error, overflow, data_out);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        wait_end(100, 1'b0, lat, to);
        checks++;
        if (to || done !== 1'b1 || lat != 52 || data_out !== res) begin
            failures++;
            $display("FAIL rerun_after_reset: got to=%b done=%b lat=%0d data=%0d want 0 1 52 %0d",
                     to, done, lat, data_out, res);
        end
        to_idle();
    endtask

    task automatic test_random();
        int lat;
        bit to;
        bit f;
        logic [63:0] d, res;
        bit ovf;
        int n;
        for (int it = 0; it < 16; it++) begin
            f = 1'($urandom);
            n = $urandom_range(0, 40);
            case ($urandom_range(0, 3))
                0:       d = 64'($urandom_range(0, 1000));
                1:       d = {$urandom, $urandom};
                2:       d = {32'd0, $urandom};
                default: d = 64'd0;
            endcase
            model(f, d, n, res, ovf);
            start(f, !f, d, 16'(n));
            wait_end(100, 1'b1, lat, to);
            checks++;
            if (to || error !== 1'b0 || overflow !== ovf || done !== !ovf || data_out !== res ||
                (!ovf && lat != n + 2)) begin
                failures++;
                $display("FAIL random it=%0d f=%b d=%h n=%0d: got to=%b err=%b ovf=%b done=%b data=%h lat=%0d want ovf=%b data=%h lat=%0d",
                         it, f, d, n, to, error, overflow, done, data_out, lat, ovf, res, n + 2);
            end
            to_idle();
        end
    endtask

    task automatic test_long_order();
        int lat;
        bit to;
        logic [63:0] d, res;
        bit ovf;
        d = {32'd0, $urandom};
        model(1'b0, d, 65535, res, ovf);
        start(1'b0, 1'b1, d, 16'hFFFF);
        wait_end(70000, 1'b0, lat, to);
        checks++;
        if (to || done !== 1'b1 || ovf || data_out !== res || lat != 65537) begin
            failures++;
            $display("FAIL long_order: got to=%b done=%b data=%0d lat=%0d want 0 1 %0d 65537",
                     to, done, data_out, lat, res);
        end
        to_idle();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        clk       = 1'b0;
        reset     = 1'b1;
        load      = 1'b0;
        fibonacci = 1'b0;
        triangle  = 1'b0;
        clear     = 1'b0;
        order     = '0;
        data_in   = '0;
        @(posedge clk); #1;
        test_reset();
        test_fib_handshake();
        test_abort();
        test_triangle();
        test_fib_boundary();
        test_mode_error();
        test_reset_mid_run();
        test_random();
        test_long_order();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
